// File: rtl/div_pkg.sv
// div_pkg: shared FSM state, step-counter sizing and parameter legality for the sequential divider.
package div_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam int MAX_BPC = 2;
    function automatic int cnt_width(input int steps);
        return steps > 1 ? $clog2(steps) : 1;
    endfunction
    function automatic bit params_legal(input int width, input int bpc);
        return width >= 2 && bpc >= 1 && bpc <= MAX_BPC && width % bpc == 0;
    endfunction
endpackage

// File: rtl/div_restore_step.sv
// div_restore_step: one combinational restoring-division step; shifts the next dividend bit into r.
module div_restore_step
    import div_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] q_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] q_out
);
    logic [WIDTH:0] sh;
    logic [WIDTH:0] diff;
    logic           ge;
    always_comb begin
        sh    = {r_in, q_in[WIDTH-1]};
        diff  = sh - {1'b0, divisor};
        ge    = sh >= {1'b0, divisor};
        r_out = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
        q_out = {q_in[WIDTH-2:0], ge};
    end
endmodule

// File: rtl/tt_um_seq_unsigned_divider.sv
// tt_um_seq_unsigned_divider: iterative restoring unsigned divider with start/done handshake.
module tt_um_seq_unsigned_divider
    import div_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int             N    = WIDTH / BITS_PER_CYCLE;
    localparam int             CW   = cnt_width(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    if (!params_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
        $error("tt_um_seq_unsigned_divider: illegal WIDTH/BITS_PER_CYCLE");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] part_rem, work_q, dvsr;
    logic [WIDTH-1:0] r1, q1, r_nxt, q_nxt;

    // work_q starts as the dividend; quotient bits fill in from the LSB as dividend bits leave the MSB
    div_restore_step #(.WIDTH(WIDTH)) u_step0 (
        .r_in(part_rem), .q_in(work_q), .divisor(dvsr), .r_out(r1), .q_out(q1)
    );
    if (BITS_PER_CYCLE == 2) begin : g_second
        div_restore_step #(.WIDTH(WIDTH)) u_step1 (
            .r_in(r1), .q_in(q1), .divisor(dvsr), .r_out(r_nxt), .q_out(q_nxt)
        );
    end else begin : g_single
        assign r_nxt = r1;
        assign q_nxt = q1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            part_rem    <= '0;
            work_q      <= '0;
            dvsr        <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == RUN) begin
                part_rem <= r_nxt;
                work_q   <= q_nxt;
                cnt      <= cnt + 1'b1;
                if (cnt == LAST) begin
                    state       <= DONE;
                    busy        <= 1'b0;
                    done        <= 1'b1;
                    quotient    <= q_nxt;
                    remainder   <= r_nxt;
                    div_by_zero <= 1'b0;
                end
            end else if (start) begin
                if (divisor == '0) begin
                    state       <= DONE;
                    done        <= 1'b1;
                    quotient    <= '1;
                    remainder   <= '1;
                    div_by_zero <= 1'b1;
                end else begin
                    state    <= RUN;
                    busy     <= 1'b1;
                    cnt      <= '0;
                    part_rem <= '0;
                    work_q   <= dividend;
                    dvsr     <= divisor;
                end
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_tt_um_seq_unsigned_divider.sv
// tb_tt_um_seq_unsigned_divider: randomized scoreboard bench for 8-bit/1-bpc and 16-bit/2-bpc dividers.
module tb_tt_um_seq_unsigned_divider;
    typedef struct {
        logic [15:0] q;
        logic [15:0] r;
        logic        z;
        int          c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy8, done8, dbz8, busy16, done16, dbz16;
    logic [7:0]  quo8, rem8;
    logic [15:0] quo16, rem16;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp8[$], exp16[$];
    exp_t        last8 = '{16'h0, 16'h0, 1'b0, 0};
    exp_t        last16 = '{16'h0, 16'h0, 1'b0, 0};

    tt_um_seq_unsigned_divider #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(b8),
        .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8), .div_by_zero(dbz8)
    );
    tt_um_seq_unsigned_divider #(.WIDTH(16), .BITS_PER_CYCLE(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .dividend(a16), .divisor(b16),
        .busy(busy16), .done(done16), .quotient(quo16), .remainder(rem16), .div_by_zero(dbz16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic [15:0] ones, input int n);
        exp_t e;
        e.z = (b == 0);
        e.q = (b == 0) ? ones : a / b;
        e.r = (b == 0) ? ones : a % b;
        e.c = (b == 0) ? 1 : n + 1;
        return e;
    endfunction

    task automatic issue8(input logic [7:0] a, input logic [7:0] b);
        int   n = 0;
        exp_t e;
        while (busy8 && n < 50) begin @(negedge clk); n++; end
        if (busy8) chk("busy8_timeout", 32'(busy8), 32'd0);
        else begin
            start8 = 1'b1; a8 = a; b8 = b;
            e = model({8'h0, a}, {8'h0, b}, 16'h00FF, 8);
            e.c += cyc;
            exp8.push_back(e);
            @(negedge clk);
            start8 = 1'b0;
        end
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b);
        int   n = 0;
        exp_t e;
        while (busy16 && n < 50) begin @(negedge clk); n++; end
        if (busy16) chk("busy16_timeout", 32'(busy16), 32'd0);
        else begin
            start16 = 1'b1; a16 = a; b16 = b;
            e = model(a, b, 16'hFFFF, 8);
            e.c += cyc;
            exp16.push_back(e);
            @(negedge clk);
            start16 = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp8.delete();
            last8 = '{16'h0, 16'h0, 1'b0, 0};
            chk("rst_busy8", 32'(busy8), 32'd0);
            chk("rst_done8", 32'(done8), 32'd0);
            chk("rst_quo8", 32'(quo8), 32'd0);
            chk("rst_rem8", 32'(rem8), 32'd0);
            chk("rst_dbz8", 32'(dbz8), 32'd0);
        end else if (done8) begin
            if (exp8.size() == 0) chk("spurious_done8", 32'(exp8.size()), 32'd1);
            else begin
                e = exp8.pop_front();
                chk("quo8", 32'(quo8), 32'(e.q));
                chk("rem8", 32'(rem8), 32'(e.r));
                chk("dbz8", 32'(dbz8), 32'(e.z));
                chk("lat8", 32'(cyc), 32'(e.c));
                last8 = e;
            end
        end else begin
            chk("hold_quo8", 32'(quo8), 32'(last8.q));
            chk("hold_rem8", 32'(rem8), 32'(last8.r));
            chk("hold_dbz8", 32'(dbz8), 32'(last8.z));
            if (exp8.size() != 0 && cyc > exp8[0].c) begin
                chk("late_done8", 32'(cyc), 32'(exp8[0].c));
                void'(exp8.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp16.delete();
            last16 = '{16'h0, 16'h0, 1'b0, 0};
            chk("rst_busy16", 32'(busy16), 32'd0);
            chk("rst_done16", 32'(done16), 32'd0);
            chk("rst_quo16", 32'(quo16), 32'd0);
            chk("rst_rem16", 32'(rem16), 32'd0);
        end else if (done16) begin
            if (exp16.size() == 0) chk("spurious_done16", 32'(exp16.size()), 32'd1);
            else begin
                e = exp16.pop_front();
                chk("quo16", 32'(quo16), 32'(e.q));
                chk("rem16", 32'(rem16), 32'(e.r));
                chk("dbz16", 32'(dbz16), 32'(e.z));
                chk("lat16", 32'(cyc), 32'(e.c));
                last16 = e;
            end
        end else begin
            chk("hold_quo16", 32'(quo16), 32'(last16.q));
            chk("hold_rem16", 32'(rem16), 32'(last16.r));
            chk("hold_dbz16", 32'(dbz16), 32'(last16.z));
            if (exp16.size() != 0 && cyc > exp16[0].c) begin
                chk("late_done16", 32'(cyc), 32'(exp16[0].c));
                void'(exp16.pop_front());
            end
        end
    end

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        issue8(8'd100, 8'd7);
        issue8(8'd200, 8'd0);
        issue8(8'd5, 8'd9);
        issue8(8'd255, 8'd1);
        issue8(8'd0, 8'd3);
        issue8(8'd0, 8'd0);
        repeat (12) @(negedge clk);
        // a second start while RUN must be dropped
        issue8(8'd50, 8'd5);
        repeat (2) @(negedge clk);
        start8 = 1'b1; a8 = 8'd9; b8 = 8'd3;
        @(negedge clk);
        start8 = 1'b0;
        repeat (12) @(negedge clk);
        // abort in cycle 4 of a RUN
        issue8(8'd100, 8'd7);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        issue8(8'd77, 8'd6);
        for (int i = 0; i < 40; i++) begin
            issue8(8'($urandom), ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (12) @(negedge clk);
        issue16(16'd65535, 16'd255);
        issue16(16'd1000, 16'd0);
        issue16(16'd12, 16'd40000);
        issue16(16'd65535, 16'd1);
        issue16(16'd65535, 16'd65535);
        for (int i = 0; i < 30; i++) begin
            issue16(16'($urandom), ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535) >> $urandom_range(0, 15)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        chk("pending8", 32'(exp8.size()), 32'd0);
        chk("pending16", 32'(exp16.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
